keypad_scan_ctrl: RTL and testbench
===================================

// Module: keypad_scan_ctrl
// PURPOSE
//  Parametrised matrix-keypad scanner replacing the fixed 4x4 pulser/decoder pair.
//  Drives one row at a time, synchronises and debounces the column returns, and
//  emits a binary key code with a valid/ack handshake plus a held and overrun status.
//  Sits between the board keypad pins and the calculator control/datapath operand loaders.
// PARAMETERS
//  ROWS      4     number of row drive lines (>=2)
//  COLS      4     number of column sense lines (>=2)
//  SCAN_DIV  1000  clk cycles per row dwell; scan tick every SCAN_DIV cycles (>=2)
//  DEBOUNCE  8     consecutive matching scan ticks required for press and for release (>=1)
//  CODE_W    localparam = $clog2(ROWS*COLS)
// PORTS
//  clk        in   1        system clock; the only clock
//  rst        in   1        reset, synchronous, active-low
//  col_i      in   COLS     raw column sense, asynchronous, active-high
//  key_ack    in   1        consumer acknowledge of pending key
//  row_o      out  ROWS     one-hot active-high row drive
//  key_code   out  CODE_W   pending key = row*COLS + col
//  key_valid  out  1        key pending; held until acknowledged
//  key_held   out  1        a debounced key is currently down
//  overrun    out  1        sticky: a press was lost while key_valid=1
// BEHAVIOUR
//  Reset (rst=0 at a clk edge): row_o=1 (row 0), key_code=0, key_valid=0, key_held=0,
//   overrun=0, divider=0, row pointer=0, debounce count=0, sync flops=0, state=IDLE.
//  col_i passes through a 2-flop synchroniser; all decisions use the synced value (2-cycle latency).
//  Divider counts 0..SCAN_DIV-1 and wraps; tick = 1 for one cycle when it equals SCAN_DIV-1.
//  Columns are sampled only on tick, for the row currently driven.
//  Sample is "single" when exactly one column bit is set; col index c = that bit position.
//  Zero or multiple column bits set = no key for that sample.
//  FSM (transitions on tick only; state and row pointer hold between ticks):
//   IDLE:    single -> DB_PRESS, latch r,c, count=1; else advance row pointer, wrap ROWS-1 -> 0.
//   DB_PRESS: row frozen at r. Same single c -> count+1. Anything else -> IDLE with row advance.
//            When count reaches DEBOUNCE -> PRESSED. With DEBOUNCE=1, go from IDLE directly
//            to PRESSED.
//   PRESSED: key_held=1, row frozen. A no-key sample -> DB_REL with count=1; otherwise stay.
//   DB_REL:  no-key sample -> count+1. Same single c -> PRESSED.
//            When count reaches DEBOUNCE -> IDLE, row advances.
//  A different key in DB_REL or PRESSED is treated as a return to PRESSED.
//   No second key is reported until a full release.
//  Press report happens in the cycle of PRESSED entry:
//   key_valid=0 -> key_code<=r*COLS+c and key_valid<=1.
//   key_valid=1 and no key_ack -> overrun<=1; key_code is unchanged.
//  Handshake: key_ack=1 while key_valid=1 -> key_valid=0 and overrun=0 next cycle.
//   key_ack while key_valid=0 has no effect.
//  Report and key_ack in the same cycle: new code loaded, key_valid stays 1, overrun not set.
//  row_o is onehot(row pointer) at all times; it updates the cycle after tick.
//  Reset mid-debounce or mid-press aborts the operation; no key is reported.
// TESTING
//  Use ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE=3.
//  T1 Scan: rst low 2 cycles, then idle.
//   -> row_o = 0001,0010,0100,1000,0001 changing every 4 cycles; key_valid=0.
//  T2 Press: hold col_i=0100 only while row 2 is driven, long enough to debounce.
//   -> row_o frozen at 0100, key_valid=1, key_code=10, key_held=1.
//   Then pulse key_ack -> key_valid=0 next cycle.
//  T3 Bounce: col_i toggles on alternate ticks during DB_PRESS.
//   -> no key_valid; scanning resumes.
//   Release bounce shorter than 3 ticks -> key_held stays 1 and no second report.
//  T4 Overrun: press key 0 and release, then press key 5 without ack.
//   -> key_code stays 0 and overrun=1. key_ack -> key_valid=0 and overrun=0.
//  T5 Edge cases:
//   - col_i=0011 -> ignored as no key.
//   - key_ack in the same cycle as a report -> new code, key_valid=1, overrun=0.
//   - rst low during PRESSED -> all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/keypad_scan_ctrl.sv
// Matrix keypad scanner: one-hot row drive, synchronised and debounced column
// sensing, and a binary key code with valid/ack handshake and overrun status.
module keypad_scan_ctrl #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 8,
  localparam int CODE_W  = $clog2(ROWS*COLS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [COLS-1:0]   col_i,
  input  logic              key_ack,
  output logic [ROWS-1:0]   row_o,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_held,
  output logic              overrun
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int NW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {IDLE, DB_PRESS, PRESSED, DB_REL} state_t;

  state_t            state;
  logic [COLS-1:0]   col_p0, col_p1;
  logic [DW-1:0]     div;
  logic [RW-1:0]     row_ptr;
  logic [NW-1:0]     cnt;
  logic [CW-1:0]     lat_c;
  logic              tick;
  logic              single;
  logic [CW-1:0]     c_now;
  logic              report;

  function automatic logic [CW-1:0] col_index(input logic [COLS-1:0] v);
    logic [CW-1:0] idx;
    idx = '0;
    for (int i = 0; i < COLS; i++)
      if (v[i]) idx = CW'(i);
    return idx;
  endfunction

  function automatic logic [RW-1:0] next_row(input logic [RW-1:0] r);
    return (r == RW'(ROWS-1)) ? '0 : r + 1'b1;
  endfunction

  function automatic logic [ROWS-1:0] onehot_row(input logic [RW-1:0] r);
    return ROWS'(1) << r;
  endfunction

  function automatic logic [CODE_W-1:0] key_index(input logic [RW-1:0] r,
                                                  input logic [CW-1:0] c);
    return CODE_W'(int'(r) * COLS + int'(c));
  endfunction

  assign tick   = (div == DW'(SCAN_DIV-1));
  assign single = $onehot(col_p1);
  assign c_now  = col_index(col_p1);

  // A press is reported on the tick that completes the debounce run.
  always_comb begin
    report = 1'b0;
    if (tick) begin
      case (state)
        IDLE:     report = single && (DEBOUNCE == 1);
        DB_PRESS: report = single && (c_now == lat_c) && (cnt == NW'(DEBOUNCE-1));
        default:  report = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      col_p0    <= '0;
      col_p1    <= '0;
      div       <= '0;
      row_ptr   <= '0;
      row_o     <= ROWS'(1);
      cnt       <= '0;
      lat_c     <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      // stage p0 -> p1: two-flop synchroniser on the raw column returns
      col_p0 <= col_i;
      col_p1 <= col_p0;
      div    <= tick ? '0 : div + 1'b1;

      if (tick) begin
        case (state)
          IDLE: begin
            if (single) begin
              lat_c <= c_now;
              cnt   <= NW'(1);
              if (DEBOUNCE == 1) begin
                state    <= PRESSED;
                key_held <= 1'b1;
              end else begin
                state <= DB_PRESS;
              end
            end else begin
              row_ptr <= next_row(row_ptr);
              row_o   <= onehot_row(next_row(row_ptr));
            end
          end
          DB_PRESS: begin
            if (single && (c_now == lat_c)) begin
              cnt <= cnt + 1'b1;
              if (report) begin
                state    <= PRESSED;
                key_held <= 1'b1;
              end
            end else begin
              state   <= IDLE;
              row_ptr <= next_row(row_ptr);
              row_o   <= onehot_row(next_row(row_ptr));
            end
          end
          PRESSED: begin
            if (!single) begin
              cnt <= NW'(1);
              if (DEBOUNCE == 1) begin
                state    <= IDLE;
                key_held <= 1'b0;
                row_ptr  <= next_row(row_ptr);
                row_o    <= onehot_row(next_row(row_ptr));
              end else begin
                state <= DB_REL;
              end
            end
          end
          default: begin
            // Any single key, even a different one, counts as still held.
            if (!single) begin
              cnt <= cnt + 1'b1;
              if (cnt == NW'(DEBOUNCE-1)) begin
                state    <= IDLE;
                key_held <= 1'b0;
                row_ptr  <= next_row(row_ptr);
                row_o    <= onehot_row(next_row(row_ptr));
              end
            end else begin
              state <= PRESSED;
            end
          end
        endcase
      end

      if (report) begin
        if (!key_valid || key_ack) begin
          key_code  <= key_index(row_ptr, c_now);
          key_valid <= 1'b1;
          overrun   <= 1'b0;
        end else begin
          overrun <= 1'b1;
        end
      end else if (key_ack && key_valid) begin
        key_valid <= 1'b0;
        overrun   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed plus randomised bench for keypad_scan_ctrl with a tick-level keypad model.
module tb_keypad_scan_ctrl;
  localparam int ROWS = 4, COLS = 4, SCAN_DIV = 4, DB = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] col_i = '0;
  logic       key_ack = 1'b0;
  logic [3:0] row_o;
  logic [3:0] key_code;
  logic       key_valid, key_held, overrun;

  always #5 clk = ~clk;

  keypad_scan_ctrl #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DB)) dut (
    .clk(clk), .rst(rst), .col_i(col_i), .key_ack(key_ack), .row_o(row_o),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held), .overrun(overrun)
  );

  int tests = 0, fails = 0;

  // keypad stimulus controls
  int         press_key = -1;
  bit         ovr_en = 0;
  logic [3:0] ovr_val = '0;
  bit         gate_en = 0;
  bit         ack_on_report = 0;
  int         ack_report_seen = 0;
  int         cyc = 0;

  // reference model: current and next values
  int m_div = 0, m_row = 0, m_run = 0, m_cand = 0;
  bit m_down = 0, m_valid = 0, m_ovr = 0;
  logic [3:0] m_s1 = '0, m_s2 = '0, m_code = '0;
  int n_div, n_row, n_run, n_cand;
  bit n_down, n_valid, n_ovr, n_ev;
  logic [3:0] n_s1, n_s2, n_code;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int key_of(input logic [3:0] v);
    if ($countones(v) != 1) return -1;
    for (int i = 0; i < COLS; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_eval();
    int k;
    int ev_code;
    n_div = m_div; n_row = m_row; n_run = m_run; n_cand = m_cand; n_down = m_down;
    n_valid = m_valid; n_ovr = m_ovr; n_s1 = m_s1; n_s2 = m_s2; n_code = m_code;
    n_ev = 0; ev_code = 0;
    if (!rst) begin
      n_div = 0; n_row = 0; n_run = 0; n_cand = 0; n_down = 0;
      n_valid = 0; n_ovr = 0; n_s1 = '0; n_s2 = '0; n_code = '0;
      return;
    end
    n_div = (m_div + 1) % SCAN_DIV;
    n_s1 = col_i;
    n_s2 = m_s1;
    if (m_div == SCAN_DIV - 1) begin
      k = key_of(m_s2);
      if (!m_down) begin
        if (k >= 0 && (m_run == 0 || k == m_cand)) begin
          n_cand = k;
          n_run = m_run + 1;
          if (n_run == DB) begin
            n_down = 1; n_run = 0; n_ev = 1; ev_code = m_row * COLS + k;
          end
        end else begin
          n_run = 0;
          n_row = (m_row + 1) % ROWS;
        end
      end else if (k < 0) begin
        n_run = m_run + 1;
        if (n_run == DB) begin
          n_down = 0; n_run = 0; n_row = (m_row + 1) % ROWS;
        end
      end else begin
        n_run = 0;
      end
    end
    if (n_ev) begin
      if (!m_valid || key_ack) begin
        n_code = 4'(ev_code); n_valid = 1; n_ovr = 0;
      end else begin
        n_ovr = 1;
      end
    end else if (key_ack && m_valid) begin
      n_valid = 0; n_ovr = 0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (ovr_en) col_i = ovr_val;
    else if (press_key >= 0 && row_o[press_key / COLS] === 1'b1) col_i = 4'(1 << (press_key % COLS));
    else col_i = '0;
    if (gate_en && ((cyc / SCAN_DIV) % 2 == 1)) col_i = '0;
    cyc++;
    model_eval();
    if (ack_on_report && n_ev && m_valid) begin
      key_ack = 1'b1;
      ack_report_seen++;
    end
    @(posedge clk);
    model_eval();
    m_div = n_div; m_row = n_row; m_run = n_run; m_cand = n_cand; m_down = n_down;
    m_valid = n_valid; m_ovr = n_ovr; m_s1 = n_s1; m_s2 = n_s2; m_code = n_code;
    #1;
    if (ack_on_report) key_ack = 1'b0;
    chk("model_row_o", row_o, 32'(1 << m_row));
    chk("model_key_valid", key_valid, m_valid);
    chk("model_key_code", key_code, m_code);
    chk("model_key_held", key_held, m_down);
    chk("model_overrun", overrun, m_ovr);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (key_valid !== 1'b1 && n < 300) begin step(); n++; end
    chk(tag, key_valid, 1);
  endtask

  task automatic wait_held(input string tag, input logic v);
    int n = 0;
    while (key_held !== v && n < 300) begin step(); n++; end
    chk(tag, key_held, v);
  endtask

  initial begin
    logic [3:0] r0;
    int hold;

    // T1: reset then free scan
    rst = 1'b0;
    step(); step();
    chk("rst_row_o", row_o, 4'b0001);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_key_code", key_code, 0);
    chk("rst_key_held", key_held, 0);
    chk("rst_overrun", overrun, 0);
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("t1_scan_row", row_o, 32'(1 << (k % 4)));
      chk("t1_no_valid", key_valid, 0);
      repeat (SCAN_DIV) step();
    end

    // T2: press key 10 (row 2, col 2), then acknowledge
    press_key = 10;
    wait_valid("t2_valid");
    chk("t2_code", key_code, 10);
    chk("t2_row_frozen", row_o, 4'b0100);
    chk("t2_held", key_held, 1);
    key_ack = 1'b1; step(); key_ack = 1'b0;
    chk("t2_ack_clears", key_valid, 0);
    press_key = -1;
    wait_held("t2_release", 1'b0);

    // T3: press bounce on alternate ticks never debounces
    press_key = 4; gate_en = 1;
    repeat (96) step();
    chk("t3_bounce_no_valid", key_valid, 0);
    chk("t3_bounce_no_held", key_held, 0);
    gate_en = 0; press_key = -1;
    r0 = row_o;
    repeat (SCAN_DIV) step();
    chk("t3_scan_resumes", (row_o != r0), 1);

    // T3: short release bounce keeps the key held without a second report
    press_key = 4;
    wait_valid("t3_rel_valid");
    chk("t3_rel_code", key_code, 4);
    key_ack = 1'b1; step(); key_ack = 1'b0;
    press_key = -1;
    repeat (5) step();
    chk("t3_short_release_held", key_held, 1);
    press_key = 4;
    repeat (40) step();
    chk("t3_still_held", key_held, 1);
    chk("t3_no_second_report", key_valid, 0);
    press_key = -1;
    wait_held("t3_full_release", 1'b0);

    // T4: overrun
    press_key = 0;
    wait_valid("t4_first_valid");
    press_key = -1;
    wait_held("t4_release", 1'b0);
    press_key = 5;
    wait_held("t4_second_held", 1'b1);
    chk("t4_code_kept", key_code, 0);
    chk("t4_overrun", overrun, 1);
    chk("t4_valid", key_valid, 1);
    key_ack = 1'b1; step(); key_ack = 1'b0;
    chk("t4_ack_valid", key_valid, 0);
    chk("t4_ack_overrun", overrun, 0);
    press_key = -1;
    wait_held("t4_release2", 1'b0);

    // T5: two columns at once is no key
    ovr_en = 1; ovr_val = 4'b0011;
    repeat (40) step();
    chk("t5_multi_no_valid", key_valid, 0);
    chk("t5_multi_no_held", key_held, 0);
    ovr_en = 0;

    // T5: ack coinciding with a report
    press_key = 3;
    wait_valid("t5_pend_valid");
    press_key = -1;
    wait_held("t5_pend_release", 1'b0);
    ack_on_report = 1; press_key = 14;
    wait_held("t5_ackrep_held", 1'b1);
    ack_on_report = 0;
    chk("t5_ackrep_seen", (ack_report_seen > 0), 1);
    chk("t5_ackrep_code", key_code, 14);
    chk("t5_ackrep_valid", key_valid, 1);
    chk("t5_ackrep_overrun", overrun, 0);
    key_ack = 1'b1; step(); key_ack = 1'b0;
    press_key = -1;
    wait_held("t5_ackrep_release", 1'b0);

    // T5: reset while a key is pressed
    press_key = 7;
    wait_held("t5_rst_held", 1'b1);
    rst = 1'b0; press_key = -1;
    step();
    chk("t5_rst_row_o", row_o, 4'b0001);
    chk("t5_rst_valid", key_valid, 0);
    chk("t5_rst_code", key_code, 0);
    chk("t5_rst_held", key_held, 0);
    chk("t5_rst_overrun", overrun, 0);
    rst = 1'b1;
    repeat (60) step();
    chk("t5_rst_no_report", key_valid, 0);

    // randomised presses, releases, noise and acks against the model
    for (int it = 0; it < 40; it++) begin
      press_key = int'($urandom_range(0, 15));
      hold = int'($urandom_range(30, 120));
      for (int c = 0; c < hold; c++) begin
        key_ack = ($urandom_range(0, 9) == 0);
        ovr_en = ($urandom_range(0, 15) == 0);
        ovr_val = 4'($urandom);
        step();
      end
      press_key = -1;
      hold = int'($urandom_range(10, 80));
      for (int c = 0; c < hold; c++) begin
        key_ack = ($urandom_range(0, 9) == 0);
        ovr_en = ($urandom_range(0, 31) == 0);
        ovr_val = 4'($urandom);
        step();
      end
    end
    key_ack = 1'b0; ovr_en = 0;
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
